seq_divider: RTL
================

# seq_divider

Multi-cycle unsigned restoring divider with start/done handshake for the modular-exponentiation datapath. It replaces the combinational divider with a registered loop, so reduction steps in `mod_exp` close timing at full clock rate. The loop retires `UNROLL` quotient bits per cycle. A compile-time switch picks between fixed-latency (side-channel-hardened) operation and early termination on small dividends.

## Interface
- `WIDTH`, 32: operand and result width in bits.
- `UNROLL`, 1: quotient bits resolved per cycle. Must divide `WIDTH`. `STEPS = WIDTH/UNROLL`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request. Sampled only while idle.
- `dividend`  in  WIDTH  numerator. Captured on accepted `start`.
- `divisor`  in  WIDTH  denominator. Captured on accepted `start`.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse when results become valid.
- `quotient`  out  WIDTH  floor(dividend/divisor).
- `remainder`  out  WIDTH  dividend mod divisor.
- `div_by_zero`  out  1  set with `done` when the captured divisor was 0.

## Operation
- FSM has two states: IDLE and RUN.
- IDLE, `start`=1 (accepted):
  - capture `D`=dividend and `N`=divisor;
  - clear the partial remainder `P`, which is WIDTH+1 bits;
  - load the step counter;
  - enter RUN and set `busy`=1.
- IDLE, `start`=0: no change.
- RUN, each cycle, UNROLL chained sub-steps, each:
  - shift `{P,D}` left by 1 (D MSB into P LSB);
  - form `T = P - {1'b0,N}`;
  - if `T[WIDTH]`=1, set quotient bit `D[0]`=0 and keep `P`;
  - otherwise set `D[0]`=1 and `P=T`.
- RUN, when the counter reaches its final step:
  - register `quotient`=D and `remainder`=P[WIDTH-1:0];
  - pulse `done`, clear `busy`, return to IDLE.
- `start` while RUN is ignored. The operands in flight are unaffected.
- `start` in the same cycle `done` is high is accepted, because the FSM is already IDLE.
- `quotient`, `remainder` and `div_by_zero` hold their values until the next completion.
- Divide by zero returns `quotient` = all ones, `remainder` = dividend, `div_by_zero`=1.
- Reset (`rst_n`=0), at any time including mid-RUN:
  - FSM goes to IDLE;
  - `busy`, `done`, `div_by_zero`, `quotient` and `remainder` all go to 0;
  - the in-flight operation is discarded. No `done` is produced for it.

## Timing
- Edge E0 accepts `start`. `busy` is high from the cycle after E0.
- Constant-time latency: `done` is high in the cycle following edge E(STEPS), i.e. STEPS+1 edges after the accepting edge. `busy` falls in that same cycle.
  - WIDTH=32, UNROLL=1: 33 edges.
  - WIDTH=32, UNROLL=4: 9 edges.
- Early-out latency is given under Configuration.
- `done` is high for exactly one cycle per accepted `start`.
- Results are valid in the `done` cycle and afterwards.

## Configuration
- Macro: `SEQ_DIV_CONST_TIME_EN`.
- Defined:
  - every operation, including dividend 0 and divisor 0, takes exactly STEPS RUN cycles;
  - divide by zero falls out of the loop naturally (every trial subtract succeeds);
  - no data-dependent control path exists. This is the default for `mod_exp` builds.
- Undefined (early-out):
  - at acceptance, count `lz` = number of leading all-zero UNROLL-bit groups of dividend;
  - pre-shift `D` left by lz*UNROLL;
  - run max(1, STEPS-lz) RUN cycles. Latency is 1 + max(1, STEPS-lz) edges;
  - divisor 0 bypasses the loop: the result is written after 1 RUN cycle (latency 2 edges) with the divide-by-zero values above;
  - results are bit-identical to the constant-time build.

## Test plan
- 100 / 7, WIDTH=32, UNROLL=1, const-time: `quotient`=14, `remainder`=2, `done` pulses 33 edges after `start`, `busy` high for 32 cycles.
- 0xFFFFFFFF / 1 and 0x80000000 / 0xFFFFFFFF, UNROLL=4: (0xFFFFFFFF, 0) and (0, 0x80000000) respectively, each `done` 9 edges after `start`.
- 0x1234 / 0: `quotient`=0xFFFFFFFF, `remainder`=0x1234, `div_by_zero`=1. Latency is 33 edges with the macro defined and 2 edges without it.
- Reissue of `start` while busy:
  - first op 50 / 3; `start` pulsed again 5 cycles later with 9 / 4;
  - required: only (16, 2) is produced, with a single `done`;
  - then `start` with 9 / 4 in the `done` cycle is accepted and yields (2, 1).
- `rst_n` low for 1 cycle at cycle 10 of 1000 / 9: all outputs read 0 and no `done` follows. A fresh 1000 / 9 then yields (111, 1).
- Early-out (macro undefined), UNROLL=1:
  - 5 / 2 gives (2, 1) with `done` 4 edges after `start` (lz=29);
  - 0 / 7 gives (0, 0) in 2 edges.
  - Randomised regression of 10k vectors matches the const-time build.

Source files
------------

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, UNROLL quotient bits per cycle, start/done handshake.
// Define SEQ_DIV_CONST_TIME_EN for fixed latency; leave it undefined for early termination on small dividends.
module seq_divider #(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int STEPS = WIDTH / UNROLL;
    localparam int CNT_W = $clog2(STEPS + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             finish;
    logic             last;

    logic [WIDTH:0]   p_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] n_q;
    logic             dz_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH:0]   p_nxt;
    logic [WIDTH-1:0] d_nxt;
    logic [WIDTH-1:0] d_load;
    logic [CNT_W-1:0] cnt_load;

    // One restoring step: shift {P,D} left, trial-subtract N, keep or restore.
    function automatic logic [2*WIDTH:0] div_step(
        input logic [WIDTH:0]   p,
        input logic [WIDTH-1:0] d,
        input logic [WIDTH-1:0] n
    );
        logic [2*WIDTH:0] pd;
        logic [WIDTH:0]   ps;
        logic [WIDTH-1:0] ds;
        logic [WIDTH:0]   t;
        pd = {p, d} << 1;
        ps = pd[2*WIDTH:WIDTH];
        ds = pd[WIDTH-1:0];
        t  = ps - {1'b0, n};
        if (t[WIDTH]) begin
            ds[0] = 1'b0;
        end else begin
            ds[0] = 1'b1;
            ps    = t;
        end
        return {ps, ds};
    endfunction

    always_comb begin
        p_nxt = p_q;
        d_nxt = d_q;
        for (int k = 0; k < UNROLL; k++) begin
            {p_nxt, d_nxt} = div_step(p_nxt, d_nxt, n_q);
        end
    end

`ifdef SEQ_DIV_CONST_TIME_EN
    assign d_load   = dividend;
    assign cnt_load = CNT_W'(STEPS);
`else
    // Count of all-zero UNROLL-bit groups at the top of the dividend.
    function automatic int lead_zero_groups(input logic [WIDTH-1:0] x);
        int   n;
        logic hit;
        n   = 0;
        hit = 1'b0;
        for (int g = STEPS - 1; g >= 0; g--) begin
            if (!hit && (x[g*UNROLL +: UNROLL] == '0)) begin
                n = n + 1;
            end else begin
                hit = 1'b1;
            end
        end
        return n;
    endfunction

    int lz;

    // Zero divisor skips the pre-shift so the raw dividend is still in D when the result is written.
    always_comb begin
        lz = lead_zero_groups(dividend);
        if (divisor == '0) begin
            d_load   = dividend;
            cnt_load = CNT_W'(1);
        end else begin
            d_load   = dividend << (lz * UNROLL);
            cnt_load = (lz >= STEPS) ? CNT_W'(1) : CNT_W'(STEPS - lz);
        end
    end
`endif

    assign last = (cnt_q == CNT_W'(1));
    assign busy = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_load;
        end else if (state == RUN) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            d_q  <= d_load;
            n_q  <= divisor;
            p_q  <= '0;
            dz_q <= (divisor == '0);
        end else if (state == RUN) begin
            d_q <= d_nxt;
            p_q <= p_nxt;
        end
    end

    // Results are captured from the final step's combinational output, so done lands one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
`ifdef SEQ_DIV_CONST_TIME_EN
                quotient  <= d_nxt;
                remainder <= p_nxt[WIDTH-1:0];
`else
                quotient  <= dz_q ? '1 : d_nxt;
                remainder <= dz_q ? d_q : p_nxt[WIDTH-1:0];
`endif
                div_by_zero <= dz_q;
            end
        end
    end

endmodule
